// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin sharing of one AXI4-Lite read port among N masters with response timeout
module mem_read_arbiter #(
    parameter int N       = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*AW-1:0] m_araddr,
    input  logic [N-1:0]    m_arvalid,
    output logic [N-1:0]    m_arready,
    output logic [DW-1:0]   m_rdata,
    output logic [1:0]      m_rresp,
    output logic [N-1:0]    m_rvalid,
    input  logic [N-1:0]    m_rready,
    output logic [AW-1:0]   s_araddr,
    output logic            s_arvalid,
    input  logic            s_arready,
    input  logic [DW-1:0]   s_rdata,
    input  logic [1:0]      s_rresp,
    input  logic            s_rvalid,
    output logic            s_rready,
    output logic            timeout_flag
);
    localparam int GW = N > 1 ? $clog2(N) : 1;
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
    state_t          state_q;
    logic [GW-1:0]   grant_q, last_q, arb_idx;
    logic [TW-1:0]   timer_q;
    logic            flag_q;
    assign timeout_flag = flag_q;
    // pick the first requester searching upward from the master after the last winner
    always_comb begin
        arb_idx = last_q;
        for (int i = N; i >= 1; i--)
            if (m_arvalid[(int'(last_q) + i) % N]) arb_idx = GW'((int'(last_q) + i) % N);
    end
    // transaction FSM: arbitrate, forward address, wait for data or time out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(N - 1);
            timer_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|m_arvalid) begin
                    grant_q <= arb_idx;
                    state_q <= ADDR;
                end
                ADDR: if (m_arvalid[grant_q] && s_arready) begin
                    state_q <= DATA;
                    timer_q <= '0;
                end else if (!m_arvalid[grant_q]) state_q <= IDLE;
                DATA: if (s_rvalid && m_rready[grant_q]) begin
                    state_q <= IDLE;
                    last_q  <= grant_q;
                end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1)) begin
                    state_q <= ERR;
                    flag_q  <= 1'b1;
                end else if (timer_q != '1) timer_q <= timer_q + 1'b1;
                ERR: if (m_rready[grant_q]) begin
                    state_q <= IDLE;
                    last_q  <= grant_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // route channels between the granted master and the slave; everyone else sees idle handshakes
    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        case (state_q)
            ADDR: begin
                s_araddr           = m_araddr[grant_q*AW +: AW];
                s_arvalid          = m_arvalid[grant_q];
                m_arready[grant_q] = s_arready;
            end
            DATA: begin
                s_rready          = m_rready[grant_q];
                m_rvalid[grant_q] = s_rvalid;
                m_rdata           = s_rdata;
                m_rresp           = s_rresp;
            end
            ERR: begin
                m_rvalid[grant_q] = 1'b1;
                m_rresp           = 2'b11;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: directed and randomized checks of the round-robin read arbiter
module tb_mem_read_arbiter;
    localparam int N = 2, AW = 32, DW = 32, TO = 8;
    logic            clk = 1'b0, rst = 1'b0;
    logic [N*AW-1:0] m_araddr;
    logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
    logic [DW-1:0]   m_rdata, s_rdata;
    logic [1:0]      m_rresp, s_rresp;
    logic [AW-1:0]   s_araddr;
    logic            s_arvalid, s_arready, s_rvalid, s_rready, timeout_flag;
    int checks = 0, passes = 0;

    mem_read_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] hashf(input logic [AW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic clear_inputs();
        m_araddr = '0; m_arvalid = '0; m_rready = '0;
        s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one transaction from master m against a zero-wait slave
    task automatic do_txn(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit arh = 0, done = 0;
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            m_arvalid = arh ? '0 : N'(1) << m;
            m_araddr[m*AW +: AW] = a;
            s_arready = 1'b1; m_rready = '1; s_rvalid = arh; s_rdata = d;
            #1;
            if (s_arvalid && s_arready) arh = 1;
            if (m_rvalid[m] && m_rready[m]) done = 1;
        end
        checks++; if (!done) $display("FAIL txn_bound master %0d got no response within %0d cycles", m, n); else passes++;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    // all masters request continuously; transaction-level model expects strict rotation
    task automatic run_engine(input int ntx, input int maxlat, input bit rnd);
        logic [AW-1:0] a [N];
        logic [AW-1:0] sa = '0;
        logic [N-1:0]  oh;
        int exp = 0, lat = 0, done = 0, cyc = 0, dcyc = 0;
        bit busy = 0;
        for (int i = 0; i < N; i++) a[i] = $urandom;
        while (done < ntx && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                m_araddr[i*AW +: AW] = a[i];
                m_rready[i] = rnd ? ($urandom_range(0, 3) != 0 || dcyc >= 4) : 1'b1;
            end
            m_arvalid = '1;
            s_arready = busy ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            s_rvalid  = busy && lat == 0;
            s_rdata   = busy ? hashf(sa) : '0;
            s_rresp   = busy ? sa[3:2] : 2'b00;
            #1;
            oh = N'(1) << exp;
            checks++; if ((m_arready & ~oh) !== '0 || (m_rvalid & ~oh) !== '0) $display("FAIL rr_exclusive arready=%b rvalid=%b expected winner %0d", m_arready, m_rvalid, exp); else passes++;
            for (int i = 0; i < N; i++) if (m_rvalid[i] && m_rready[i]) begin
                checks++; if (i !== exp || m_rdata !== hashf(a[i]) || m_rresp !== a[i][3:2] || s_rready !== 1'b1)
                    $display("FAIL rr_response master %0d data %h resp %b s_rready %b, expected master %0d data %h resp %b", i, m_rdata, m_rresp, s_rready, exp, hashf(a[i]), a[i][3:2]);
                else passes++;
                a[i] = $urandom;
                exp = (exp + 1) % N;
                done++;
                busy = 0;
            end
            if (busy && lat > 0) lat--;
            dcyc++;
            if (s_arvalid && s_arready) begin
                checks++; if (m_arready !== oh || s_araddr !== a[exp]) $display("FAIL rr_grant arready %b addr %h, expected %b addr %h", m_arready, s_araddr, oh, a[exp]); else passes++;
                busy = 1; sa = a[exp]; dcyc = 0;
                lat = rnd ? $urandom_range(0, maxlat) : 0;
            end
        end
        checks++; if (done < ntx) $display("FAIL rr_bound completed %0d of %0d transactions", done, ntx); else passes++;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
        m_arvalid = '1; s_arready = 1'b1; s_rvalid = 1'b1; m_rready = '1; s_rdata = 32'hFFFF_FFFF; s_rresp = 2'b10;
        #1;
        checks++; if ({m_arready, m_rvalid, s_arvalid, s_rready, m_rresp} !== '0) $display("FAIL reset_ctrl arready %b rvalid %b s_arvalid %b s_rready %b rresp %b, required all 0", m_arready, m_rvalid, s_arvalid, s_rready, m_rresp); else passes++;
        checks++; if (s_araddr !== '0 || m_rdata !== '0) $display("FAIL reset_data s_araddr %h m_rdata %h, required 0", s_araddr, m_rdata); else passes++;
        checks++; if (timeout_flag !== 1'b0) $display("FAIL reset_flag got %b want 0", timeout_flag); else passes++;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        m_arvalid = 2'b01; m_araddr[0 +: AW] = 32'h8000_0000; s_arready = 1'b1; m_rready = '1;
        #1;
        checks++; if (s_arvalid !== 1'b0) $display("FAIL single_arb_cycle s_arvalid %b want 0", s_arvalid); else passes++;
        @(negedge clk); #1;
        checks++; if (m_arready !== 2'b01 || s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000) $display("FAIL single_ar arready %b s_arvalid %b addr %h, want 01 1 80000000", m_arready, s_arvalid, s_araddr); else passes++;
        @(negedge clk);
        m_arvalid = '0; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (m_rvalid !== 2'b01 || m_rdata !== 32'hDEAD_BEEF || s_rready !== 1'b1) $display("FAIL single_r rvalid %b data %h s_rready %b, want 01 deadbeef 1", m_rvalid, m_rdata, s_rready); else passes++;
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        checks++; if (m_rvalid !== 2'b00 || s_arvalid !== 1'b0) $display("FAIL single_idle rvalid %b s_arvalid %b, want 00 0", m_rvalid, s_arvalid); else passes++;
        clear_inputs();
    endtask

    task automatic test_round_robin();
        do_reset();
        run_engine(4, 0, 1'b0);
    endtask

    task automatic test_hold_during_data();
        do_reset();
        @(negedge clk);
        m_arvalid = 2'b01; m_araddr[0 +: AW] = 32'h500; s_arready = 1'b1; m_rready = '1;
        @(negedge clk); #1;
        checks++; if (m_arready !== 2'b01) $display("FAIL hold_ar0 arready %b want 01", m_arready); else passes++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            m_arvalid = 2'b10; m_araddr[AW +: AW] = 32'h1000;
            #1;
            checks++; if (m_arready !== 2'b00 || m_rvalid !== 2'b00) $display("FAIL hold_wait%0d arready %b rvalid %b, want 00 00", k, m_arready, m_rvalid); else passes++;
        end
        @(negedge clk);
        s_rvalid = 1'b1; s_rdata = 32'hAAAA;
        #1;
        checks++; if (m_arready !== 2'b00 || m_rvalid !== 2'b01) $display("FAIL hold_r0 arready %b rvalid %b, want 00 01", m_arready, m_rvalid); else passes++;
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        checks++; if (m_arready !== 2'b00 || s_arvalid !== 1'b0) $display("FAIL hold_idle arready %b s_arvalid %b, want 00 0", m_arready, s_arvalid); else passes++;
        @(negedge clk); #1;
        checks++; if (m_arready !== 2'b10 || s_araddr !== 32'h1000) $display("FAIL hold_ar1 arready %b addr %h, want 10 00001000", m_arready, s_araddr); else passes++;
        @(negedge clk);
        m_arvalid = '0; s_rvalid = 1'b1;
        #1;
        checks++; if (m_rvalid !== 2'b10) $display("FAIL hold_r1 rvalid %b want 10", m_rvalid); else passes++;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk);
        m_arvalid = 2'b01; m_araddr[0 +: AW] = 32'h100; s_arready = 1'b1; m_rready = '1; s_rdata = 32'hFFFF_FFFF; s_rresp = 2'b01;
        @(negedge clk); #1;
        checks++; if (m_arready !== 2'b01) $display("FAIL to_ar arready %b want 01", m_arready); else passes++;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            m_arvalid = '0;
            #1;
            checks++; if ({m_rvalid, timeout_flag} !== 3'b000) $display("FAIL to_wait%0d rvalid %b flag %b, want 00 0", k, m_rvalid, timeout_flag); else passes++;
        end
        @(negedge clk); #1;
        checks++; if (m_rvalid !== 2'b01 || m_rresp !== 2'b11 || m_rdata !== '0 || s_rready !== 1'b0) $display("FAIL to_err rvalid %b resp %b data %h s_rready %b, want 01 11 0 0", m_rvalid, m_rresp, m_rdata, s_rready); else passes++;
        checks++; if (timeout_flag !== 1'b1) $display("FAIL to_flag got %b want 1", timeout_flag); else passes++;
        @(negedge clk); #1;
        checks++; if (m_rvalid !== 2'b00 || timeout_flag !== 1'b1) $display("FAIL to_after rvalid %b flag %b, want 00 1", m_rvalid, timeout_flag); else passes++;
        clear_inputs();
        do_txn(1, 32'h200, 32'h7777);
        checks++; if (timeout_flag !== 1'b1) $display("FAIL to_sticky got %b want 1", timeout_flag); else passes++;
    endtask

    task automatic test_async_reset();
        do_reset();
        do_txn(0, 32'h40, 32'h1111);
        @(negedge clk);
        m_arvalid = 2'b10; m_araddr[AW +: AW] = 32'h2000; s_arready = 1'b1; m_rready = '0;
        @(negedge clk); #1;
        checks++; if (m_arready !== 2'b10) $display("FAIL ar_pre_grant arready %b want 10", m_arready); else passes++;
        @(negedge clk);
        m_arvalid = '0; s_rvalid = 1'b1; s_rdata = 32'h5555;
        #1;
        checks++; if (m_rvalid !== 2'b10) $display("FAIL ar_pre_data rvalid %b want 10", m_rvalid); else passes++;
        #1 rst = 1'b1;
        #1;
        checks++; if ({m_arready, m_rvalid, s_arvalid, s_rready} !== '0 || m_rdata !== '0) $display("FAIL ar_outputs arready %b rvalid %b s_arvalid %b s_rready %b data %h, want all 0", m_arready, m_rvalid, s_arvalid, s_rready, m_rdata); else passes++;
        #1 rst = 1'b0;
        s_rvalid = 1'b0;
        @(negedge clk);
        m_arvalid = 2'b11; m_araddr = {32'h3000, 32'h4000};
        @(negedge clk); #1;
        checks++; if (m_arready !== 2'b01 || s_araddr !== 32'h4000) $display("FAIL ar_regrant arready %b addr %h, want 01 00004000", m_arready, s_araddr); else passes++;
        clear_inputs();
    endtask

    task automatic test_rready_hold();
        do_reset();
        @(negedge clk);
        m_arvalid = 2'b01; m_araddr[0 +: AW] = 32'h300; s_arready = 1'b1;
        @(negedge clk); #1;
        checks++; if (m_arready !== 2'b01) $display("FAIL rh_ar arready %b want 01", m_arready); else passes++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m_arvalid = '0; s_rvalid = 1'b1; s_rdata = 32'h1234_5678; m_rready = '0;
            #1;
            checks++; if (s_rready !== 1'b0 || m_rvalid !== 2'b01 || m_rdata !== 32'h1234_5678) $display("FAIL rh_hold%0d s_rready %b rvalid %b data %h, want 0 01 12345678", k, s_rready, m_rvalid, m_rdata); else passes++;
        end
        @(negedge clk);
        m_rready = 2'b01;
        #1;
        checks++; if (s_rready !== 1'b1 || m_rvalid !== 2'b01) $display("FAIL rh_accept s_rready %b rvalid %b, want 1 01", s_rready, m_rvalid); else passes++;
        @(negedge clk); #1;
        checks++; if (m_rvalid !== 2'b00 || s_rready !== 1'b0) $display("FAIL rh_done rvalid %b s_rready %b, want 00 0", m_rvalid, s_rready); else passes++;
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        run_engine(40, 2, 1'b1);
        checks++; if (timeout_flag !== 1'b0) $display("FAIL rand_flag got %b want 0", timeout_flag); else passes++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_hold_during_data();
        test_timeout();
        test_async_reset();
        test_rready_hold();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Round-robin arbiter that shares one AXI4-Lite read port (AR/R channels) between N read masters.
- Index 0 is the instruction fetch unit; index 1 is the load/store unit.
- Sits between the core's fetch/load units and the memory/SRAM slave.
- One outstanding transaction at a time; the grant is held from AR handshake through R handshake.
- A response-timeout counter returns an error response if the slave hangs.

Parameters:
- N, 2, number of read masters (≥2).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 256, max cycles in DATA before forced error response; 0 disables.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- m_araddr  in  N*AW  master read addresses, master i at [i*AW +: AW].
- m_arvalid  in  N  per-master AR valid.
- m_arready  out  N  per-master AR ready.
- m_rdata  out  DW  read data, broadcast to all masters.
- m_rresp  out  2  read response, broadcast.
- m_rvalid  out  N  per-master R valid.
- m_rready  in  N  per-master R ready.
- s_araddr  out  AW  slave address.
- s_arvalid  out  1  slave AR valid.
- s_arready  in  1  slave AR ready.
- s_rdata  in  DW  slave read data.
- s_rresp  in  2  slave response.
- s_rvalid  in  1  slave R valid.
- s_rready  out  1  slave R ready.
- timeout_flag  out  1  sticky; set on any timeout, cleared only by rst.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, grant=0, last_grant=N-1 (master 0 wins first), timer=0, timeout_flag=0.
  - All m_arready, m_rvalid, s_arvalid, s_rready = 0; s_araddr, m_rdata, m_rresp = 0.
  - Reset mid-transaction aborts it with no response. Masters must re-issue.
- States: IDLE, ADDR, DATA, ERR. Outputs are combinational from registered state/grant; non-granted masters always see arready=0, rvalid=0.
- IDLE:
  - Drives nothing to the slave.
  - If any m_arvalid, grant = first requesting index searching upward from last_grant+1 (mod N); go to ADDR next cycle.
  - Arbitration costs 1 cycle.
- ADDR:
  - s_araddr=m_araddr[grant]; s_arvalid=m_arvalid[grant]; m_arready[grant]=s_arready.
  - On s_arvalid&&s_arready: go to DATA, timer=0.
  - If m_arvalid[grant] drops before the handshake (protocol violation): return to IDLE with no response and last_grant unchanged.
- DATA:
  - s_rready=m_rready[grant]; m_rvalid[grant]=s_rvalid; m_rdata=s_rdata; m_rresp=s_rresp.
  - On s_rvalid&&s_rready: go to IDLE, last_grant=grant.
  - Otherwise timer increments each cycle. If TIMEOUT≠0 and timer reaches TIMEOUT-1 with no handshake: go to ERR and set timeout_flag.
  - Timer width $clog2(TIMEOUT+1) and saturates; no wrap.
- ERR:
  - m_rvalid[grant]=1, m_rresp=2'b11 (DECERR), m_rdata=0, s_rready=0.
  - On m_rready[grant]: go to IDLE, last_grant=grant.
  - A late slave response after timeout is unsupported.
- Latency with a zero-wait slave: AR handshake 1 cycle after the request is seen; R in the next cycle at the earliest. Minimum 3 cycles per transaction, including the IDLE arbitration cycle.
- Fairness: with all masters continuously requesting, grants rotate 0,1,…,N-1; no master waits more than N-1 transactions.
- Requests arriving during ADDR/DATA/ERR are held (arready=0) until IDLE.
- Simultaneous requests in IDLE are resolved only by round-robin order.

Test Plan:
- Reset, then master0 requests 0x80000000 with a zero-wait slave returning 0xDEADBEEF → AR handshake in cycle 2, m_rvalid[0] with data 0xDEADBEEF in cycle 3, m_rvalid[1]=0 throughout.
- Masters 0 and 1 both request continuously for 4 transactions → grant order 0,1,0,1; each s_araddr matches the granted master's address.
- Master1 asserts arvalid while master0 is in DATA with a slave delay of 5 cycles → m_arready[1] stays 0 until master0's R handshake, then master1 is granted after the IDLE cycle.
- Slave never asserts rvalid, TIMEOUT=8 → m_rvalid[grant]=1, m_rresp=2'b11, m_rdata=0 8 cycles after the AR handshake; timeout_flag=1 and stays set.
- Assert rst asynchronously in the middle of DATA → all outputs 0 immediately, state IDLE; next request granted to master0.
- Master holds rready=0 for 3 cycles while the slave has rvalid=1 → s_rready=0 for those cycles, data held, handshake completes on the cycle rready rises.
